lzc_normalize_pipe: RTL and testbench



---
 rtl/lzc_normalize_pipe.sv | 87 ++++++++
 tb/tb_lzc_normalize_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lzc_normalize_pipe.sv
// lzc_normalize_pipe: two-stage pipelined leading-zero counter and left normalizer with valid/ready handshake
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data (operand, MSB = bit WIDTH-1);
//        out_valid/out_ready; out_count (0..WIDTH leading zeros); out_zero (operand was all zero);
//        out_norm (in_data << out_count), present only when LZN_NORM_EN is defined.
`timescale 1ns/1ps
module lzc_normalize_pipe #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
`ifdef LZN_NORM_EN
  ,
  output logic [WIDTH-1:0] out_norm
`endif
);
  localparam int LG = $clog2(WIDTH);
  localparam int P  = 1 << LG;
  // Halving reduction: each level merges (all-zero, count) pairs of adjacent nodes, upper half first.
  function automatic logic [LG-1:0] tree_lzc(input logic [P-1:0] v);
    logic [P-1:0]  z;
    logic [LG-1:0] c [P];
    z = ~v;
    for (int i = 0; i < P; i++) c[i] = '0;
    for (int k = 0; k < LG; k++)
      for (int i = 0; i < (P >> (k + 1)); i++) begin
        c[i] = z[2*i+1] ? (c[2*i] | LG'(1 << k)) : c[2*i+1];
        z[i] = z[2*i+1] & z[2*i];
      end
    return c[0];
  endfunction
  logic             rdy_q, adv1, adv2, in_fire, zero_d;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic             s1_zero_q, s2_zero_q;
  logic [CNT_W-1:0] s1_cnt_q, s2_cnt_q, cnt_d;
  logic [P-1:0]     pad;
  // Ones padded below the LSB sit after any real 1, so they never shorten the count.
  assign pad        = ~(P'(~in_data) << (P - WIDTH));
  assign zero_d     = ~|in_data;
  assign cnt_d      = zero_d ? CNT_W'(WIDTH) : CNT_W'(tree_lzc(pad));
  assign adv2       = !s2_valid_q || out_ready;
  assign adv1       = !s1_valid_q || adv2;
  // rdy_q keeps in_ready low through reset and rises on the first edge after release.
  assign in_ready   = rdy_q && adv1;
  assign in_fire    = in_valid && in_ready;
  assign s1_valid_d = adv1 ? in_fire : s1_valid_q;
  assign s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_cnt_q  <= cnt_d;
      s1_zero_q <= zero_d;
    end
    if (adv2 && s1_valid_q) begin
      s2_cnt_q  <= s1_cnt_q;
      s2_zero_q <= s1_zero_q;
    end
  end
  assign out_valid = s2_valid_q;
  assign out_count = s2_valid_q ? s2_cnt_q : '0;
  assign out_zero  = s2_valid_q && s2_zero_q;
`ifdef LZN_NORM_EN
  logic [WIDTH-1:0] s1_data_q, s2_norm_q;
  always_ff @(posedge clk) begin
    if (in_fire) s1_data_q <= in_data;
    if (adv2 && s1_valid_q) s2_norm_q <= s1_data_q << s1_cnt_q;
  end
  assign out_norm = s2_valid_q ? s2_norm_q : '0;
`endif
endmodule

// File: tb/tb_lzc_normalize_pipe.sv
// tb_lzc_normalize_pipe: scoreboard bench for lzc_normalize_pipe at WIDTH=64 and WIDTH=53
`timescale 1ns/1ps
module tb_lzc_normalize_pipe;
  logic        clk = 0, rst_n = 0;
  logic        a_iv = 0, a_ir, a_ov, a_or = 1, a_z;
  logic [63:0] a_id = '0;
  logic [6:0]  a_cnt;
  logic        b_iv = 0, b_ir, b_ov, b_or = 1, b_z;
  logic [52:0] b_id = '0;
  logic [5:0]  b_cnt;
`ifdef LZN_NORM_EN
  logic [63:0] a_norm;
  logic [52:0] b_norm;
`endif
  int n_chk = 0, n_fail = 0;
  typedef struct {int cnt; bit zero; logic [63:0] norm;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  bit a_hold = 0;
  logic [6:0] a_prev;
  always #5 clk = ~clk;
  lzc_normalize_pipe #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_count(a_cnt), .out_zero(a_z)
`ifdef LZN_NORM_EN
    , .out_norm(a_norm)
`endif
  );
  lzc_normalize_pipe #(.WIDTH(53)) u53 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_count(b_cnt), .out_zero(b_z)
`ifdef LZN_NORM_EN
    , .out_norm(b_norm)
`endif
  );
  // Reference: scan from the MSB for the first one; normalize by a plain shift trimmed to w bits.
  function automatic exp_t model(logic [63:0] v, int w);
    exp_t e;
    logic [63:0] m;
    e.cnt = w;
    for (int i = 0; i < w && e.cnt == w; i++) if (v[w-1-i]) e.cnt = i;
    e.zero = (e.cnt == w);
    m = '1;
    m = ~(m << w);
    e.norm = (v << e.cnt) & m;
    return e;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic send(bit b, logic [63:0] d);
    int t = 0;
    if (b) begin b_iv = 1; b_id = d[52:0]; end
    else begin a_iv = 1; a_id = d; end
    @(negedge clk);
    while (!(b ? b_ir : a_ir) && t < 200) begin t++; @(negedge clk); end
    if (t == 200) chk("accept_timeout", b ? b_ir : a_ir, 1);
    @(posedge clk); #1;
    if (b) b_iv = 0; else a_iv = 0;
  endtask
  always @(negedge rst_n) begin
    qa.delete();
    qb.delete();
    a_hold = 0;
  end
  always @(negedge clk) begin
    if (rst_n && a_iv && a_ir) qa.push_back(model(a_id, 64));
    if (rst_n && b_iv && b_ir) qb.push_back(model({11'b0, b_id}, 53));
  end
  always @(negedge clk) if (rst_n) begin
    if (a_hold) begin
      chk("hold_valid64", a_ov, 1);
      chk("hold_count64", a_cnt, a_prev);
    end
    if (a_ov && a_or) begin
      if (qa.size() == 0) chk("spurious_out64", a_ov, 0);
      else begin
        ea = qa.pop_front();
        chk("count64", a_cnt, ea.cnt);
        chk("zero64", a_z, ea.zero);
`ifdef LZN_NORM_EN
        chk("norm64", a_norm, ea.norm);
`endif
      end
    end
    a_hold = a_ov && !a_or;
    a_prev = a_cnt;
  end
  always @(negedge clk) if (rst_n && b_ov && b_or) begin
    if (qb.size() == 0) chk("spurious_out53", b_ov, 0);
    else begin
      eb = qb.pop_front();
      chk("count53", b_cnt, eb.cnt);
      chk("zero53", b_z, eb.zero);
`ifdef LZN_NORM_EN
      chk("norm53", b_norm, eb.norm);
`endif
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] d;
    bit w;
    #3;
    chk("rst_out_valid", a_ov, 0);
    chk("rst_in_ready", a_ir, 0);
    chk("rst_out_count", a_cnt, 0);
    chk("rst_out_zero", a_z, 0);
    chk("rst_in_ready53", b_ir, 0);
    #9 rst_n = 1;
    #1 chk("ready_before_edge", a_ir, 0);
    @(negedge clk) chk("ready_after_edge", a_ir, 1);
    @(posedge clk); #1;
    send(0, 64'h0000_0000_0000_07FF);
    @(negedge clk) chk("latency_cycle1", a_ov, 0);
    @(negedge clk) chk("latency_cycle2", a_ov, 1);
    @(posedge clk); #1;
    send(0, 64'h8888_8888_8888_8FFF);
    send(0, 64'h0);
    send(0, 64'h1);
    send(1, 64'h1);
    send(1, 64'h0);
    repeat (4) @(posedge clk);
    #1 a_or = 0;
    send(0, 64'h1);
    send(0, 64'h2);
    a_iv = 1;
    a_id = 64'h4;
    repeat (3) begin @(negedge clk); chk("bp_in_ready_low", a_ir, 0); end
    @(posedge clk); #1 a_or = 1;
    @(negedge clk);
    chk("bp_c_accepted", a_ir, 1);
    chk("bp_stream_valid", a_ov, 1);
    @(posedge clk); #1 a_iv = 0;
    repeat (2) begin @(negedge clk); chk("bp_stream_valid", a_ov, 1); end
    @(posedge clk); #1 a_or = 0;
    send(0, 64'h10);
    send(0, 64'h20);
    #1 rst_n = 0;
    #1;
    chk("midrst_out_valid", a_ov, 0);
    chk("midrst_in_ready", a_ir, 0);
    chk("midrst_out_count", a_cnt, 0);
    #1 rst_n = 1;
    a_or = 1;
    repeat (4) begin @(negedge clk); chk("post_reset_idle", a_ov, 0); end
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          w = 1'($urandom_range(0, 1));
          d = {$urandom, $urandom} >> $urandom_range(0, 64);
          if ($urandom_range(0, 15) == 0) d = '0;
          send(w, d);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
      end
      begin
        repeat (400) begin @(posedge clk); #1 a_or = ($urandom_range(0, 2) != 0); end
        a_or = 1;
      end
    join
    a_or = 1;
    for (int t = 0; t < 50 && (qa.size() != 0 || qb.size() != 0); t++) @(posedge clk);
    @(negedge clk);
    chk("drain64", qa.size(), 0);
    chk("drain53", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
